div_ctrl: RTL and testbench
===========================

# div_ctrl

Shared-divider controller for the CPU's divide peripheral. Arbitrates between two requesters (index 0: core execute stage, index 1: memory-mapped peripheral port), accepts one operation at a time through a valid/ready handshake, and sequences an iterative restoring divide of WIDTH steps. It returns quotient, remainder and a divide-by-zero flag on a per-requester response handshake. It replaces direct combinational use of the divider so the divide path leaves the critical timing path.

## Interface

- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  2  request present, bit i = requester i.
- req_ready  out  2  request accepted this cycle when req_valid[i] & req_ready[i].
- req_dividend  in  2*WIDTH  dividend; slice [i*WIDTH +: WIDTH] belongs to requester i.
- req_divisor  in  2*WIDTH  divisor; same slicing.
- rsp_valid  out  2  response held for requester i.
- rsp_ready  in  2  requester i takes the response.
- rsp_result  out  WIDTH  quotient; valid while any rsp_valid bit is high.
- rsp_remainder  out  WIDTH  remainder; same validity.
- rsp_dz  out  1  divisor was zero; same validity.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - Grant is round-robin. If only one req_valid bit is set, that requester is granted. If both are set, grant goes to the requester not served last.
  - last_grant resets to 1, so requester 0 wins the first contention.
  - req_ready[g] is high combinationally only for the granted requester in IDLE. Both bits are 0 in RUN and DONE.
- Accept:
  - Latch operands, the owner index and last_grant.
  - Divisor ≠ 0: go to RUN with step counter = WIDTH.
  - Divisor = 0: go directly to DONE with result = all ones, remainder = dividend, dz = 1.
- RUN:
  - One restoring step per cycle: shift the {partial remainder, quotient} pair left by 1, trial-subtract the divisor, keep the difference and set the quotient LSB if the difference is non-negative, else restore.
  - The partial remainder is WIDTH+1 bits wide, so no carry is lost.
  - The counter decrements each step. When it reaches 0, go to DONE.
- DONE:
  - rsp_valid[owner] = 1. Outputs are held stable until rsp_ready[owner] = 1, then return to IDLE.
  - rsp_ready on the non-owner bit is ignored.
- Reset, including mid-RUN or in DONE: state = IDLE, rsp_valid = 0, rsp_result/rsp_remainder = 0, rsp_dz = 0, counter = 0, last_grant = 1. Any in-flight operation is discarded and no response is issued.
- Operands on the request ports may change freely after acceptance.

## Timing

- Accept edge at cycle t. Non-zero divisor: rsp_valid rises at t+WIDTH+1 (17 for WIDTH=16).
- Divisor zero: rsp_valid rises at t+1.
- Response handshake at cycle r: the next accept can occur at r+1, the earliest cycle req_ready can be high again. Back-to-back throughput is WIDTH+2 cycles per operation when rsp_ready is held high.
- No output depends combinationally on rsp_ready. req_ready depends combinationally only on req_valid, state and last_grant.

## Configuration

- DIV_CTRL_SIGNED_EN defined:
  - Operands are two's complement. Magnitudes are divided, then the quotient is negated if the signs differ and the remainder takes the dividend's sign.
  - Divide-by-zero returns the same values as unsigned.
  - Most-negative / −1 returns quotient = dividend, remainder = 0, dz = 0, with no RUN phase: response at t+1.
- Not defined: unsigned only. The sign-fixup logic is absent.

## Structure

- Shared package div_pkg:
  - state enum (IDLE/RUN/DONE);
  - DIV_WIDTH default constant;
  - requester index constants REQ_CORE = 0, REQ_PERIPH = 1.
- Sub-module div_step: one combinational restoring step taking (partial remainder, quotient, divisor) and producing the next (partial remainder, quotient). It is instantiated once and iterated by the FSM.

## Test plan

- Unsigned requester 0, 28 / 11 → result 2, remainder 6, dz 0; rsp_valid exactly 17 cycles after accept.
- Back-to-back requester 0: 36 / 6 then 37 / 6 → (6, 0) then (6, 1); second req_ready high the cycle after the first response handshake.
- Both valid in the same cycle: 100 / 7 on req 0 and 50 / 5 on req 1.
  - Req 0 is served first → (14, 2); then req 1 → (10, 0).
  - Repeat the contention: req 1 now wins.
- Divide by zero, 1234 / 0 → result 0xFFFF, remainder 1234, dz 1, one cycle after accept.
- rst asserted at step 8 of 28 / 11: no rsp_valid ever appears, req_ready returns next cycle, and a new 37 / 6 completes correctly.
- Signed build: −7 / 2 → (−3, −1). −32768 / −1 → (−32768, 0) at t+1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the divide controller: FSM states, default width and requester indices.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIV_WIDTH = 16;

   localparam logic REQ_CORE   = 1'b0;
   localparam logic REQ_PERIPH = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {remainder, quotient} left, trial-subtract, keep or restore.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] dvs_ext;
   logic [WIDTH:0]   diff;
   logic             fits;

   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      dvs_ext = {2'b00, dvs};
      fits    = (shifted >= dvs_ext);
      diff    = shifted[WIDTH:0] - dvs_ext[WIDTH:0];
      rem_out = fits ? diff : shifted[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/div_ctrl.sv
// Two-requester round-robin controller around an iterative restoring divider.
// Define DIV_CTRL_SIGNED_EN to build the two's-complement variant with sign fix-up.
module div_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_dividend,
   input  logic [2*WIDTH-1:0] req_divisor,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic [WIDTH-1:0]   rsp_remainder,
   output logic               rsp_dz
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t state, state_n;
   logic [CW-1:0]    cnt;
   logic             owner, last_grant, grant, accept;
   logic [WIDTH:0]   rem, rem_n;
   logic [WIDTH-1:0] quo, quo_n, dvsr;
   logic [WIDTH-1:0] sel_dvd, sel_dvs, op_dvd, op_dvs, fin_q, fin_r;
   logic             ovf, dvs_zero;

   always_comb begin
      grant     = REQ_CORE;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      unique case (req_valid)
         2'b10:   grant = REQ_PERIPH;
         2'b11:   grant = ~last_grant;
         default: grant = REQ_CORE;
      endcase
      if (state == IDLE && req_valid != 2'b00)
         req_ready[grant] = 1'b1;
      if (state == DONE)
         rsp_valid[owner] = 1'b1;
      accept = |(req_valid & req_ready);
   end

   always_comb begin
      sel_dvd  = grant ? req_dividend[WIDTH +: WIDTH] : req_dividend[0 +: WIDTH];
      sel_dvs  = grant ? req_divisor[WIDTH +: WIDTH]  : req_divisor[0 +: WIDTH];
      dvs_zero = (sel_dvs == '0);
   end

`ifdef DIV_CTRL_SIGNED_EN
   logic neg_q, neg_r;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   // The core always divides magnitudes; signs are restored on the final step.
   always_comb begin
      op_dvd = sel_dvd[WIDTH-1] ? negate(sel_dvd) : sel_dvd;
      op_dvs = sel_dvs[WIDTH-1] ? negate(sel_dvs) : sel_dvs;
      ovf    = (sel_dvd == {1'b1, {(WIDTH-1){1'b0}}}) && (&sel_dvs);
      fin_q  = neg_q ? negate(quo_n) : quo_n;
      fin_r  = neg_r ? negate(rem_n[WIDTH-1:0]) : rem_n[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         neg_q <= sel_dvd[WIDTH-1] ^ sel_dvs[WIDTH-1];
         neg_r <= sel_dvd[WIDTH-1];
      end
   end
`else
   always_comb begin
      op_dvd = sel_dvd;
      op_dvs = sel_dvs;
      ovf    = 1'b0;
      fin_q  = quo_n;
      fin_r  = rem_n[WIDTH-1:0];
   end
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .quo_in  (quo),
      .dvs     (dvsr),
      .rem_out (rem_n),
      .quo_out (quo_n)
   );

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (accept) state_n = (dvs_zero || ovf) ? DONE : RUN;
         RUN:     if (cnt == CW'(1)) state_n = DONE;
         DONE:    if (rsp_ready[owner]) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         owner         <= REQ_CORE;
         last_grant    <= REQ_PERIPH;
         rsp_result    <= '0;
         rsp_remainder <= '0;
         rsp_dz        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (accept) begin
               owner      <= grant;
               last_grant <= grant;
               if (dvs_zero) begin
                  cnt           <= '0;
                  rsp_result    <= '1;
                  rsp_remainder <= sel_dvd;
                  rsp_dz        <= 1'b1;
               end else if (ovf) begin
                  cnt           <= '0;
                  rsp_result    <= sel_dvd;
                  rsp_remainder <= '0;
                  rsp_dz        <= 1'b0;
               end else begin
                  cnt <= CW'(WIDTH);
               end
            end
            RUN: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  rsp_result    <= fin_q;
                  rsp_remainder <= fin_r;
                  rsp_dz        <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && accept) begin
         rem  <= '0;
         quo  <= op_dvd;
         dvsr <= op_dvs;
      end else if (state == RUN) begin
         rem  <= rem_n;
         quo  <= quo_n;
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with an arithmetic reference model checked every cycle.
`timescale 1ns/1ps
module tb_div_ctrl;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [1:0]     req_valid = 2'b00;
   logic [1:0]     req_ready;
   logic [2*W-1:0] req_dividend = '0;
   logic [2*W-1:0] req_divisor  = '0;
   logic [1:0]     rsp_valid;
   logic [1:0]     rsp_ready = 2'b00;
   logic [W-1:0]   rsp_result, rsp_remainder;
   logic           rsp_dz;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int acc_cyc = 0;
   int rsp_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_ctrl #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_remainder (rsp_remainder),
      .rsp_dz        (rsp_dz)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   typedef struct {
      logic       owner;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic       dz;
      int         lat;
      int         acc;
   } exp_t;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.owner = 1'b0;
      e.acc   = 0;
      e.dz    = 1'b0;
      e.lat   = W + 1;
      if (b == 0) begin
         e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
      end else begin
`ifdef DIV_CTRL_SIGNED_EN
         if (a == 16'h8000 && b == 16'hFFFF) begin
            e.q = a; e.r = '0; e.lat = 1;
         end else begin
            e.q = W'($signed(a) / $signed(b));
            e.r = W'($signed(a) % $signed(b));
         end
`else
         e.q = a / b;
         e.r = a % b;
`endif
      end
      return e;
   endfunction

   exp_t exp_q[$];
   logic last_m = 1'b1;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         last_m = 1'b1;
      end else if (exp_q.size() == 0) begin
         chk("rsp_valid_idle", 32'(rsp_valid), 32'(0));
         if (req_valid != 2'b00) begin
            logic g;
            exp_t e;
            g = (req_valid == 2'b11) ? ~last_m : req_valid[1];
            chk("req_ready_grant", 32'(req_ready), g ? 32'd2 : 32'd1);
            if ((req_valid & req_ready) != 2'b00) begin
               e = model(req_dividend[g*W +: W], req_divisor[g*W +: W]);
               e.owner = g;
               e.acc   = cyc;
               exp_q.push_back(e);
               last_m = g;
            end
         end
      end else begin
         exp_t e;
         e = exp_q[0];
         chk("req_ready_busy", 32'(req_ready), 32'(0));
         if (cyc - e.acc < e.lat) begin
            chk("rsp_valid_early", 32'(rsp_valid), 32'(0));
         end else begin
            chk("rsp_valid_owner", 32'(rsp_valid), e.owner ? 32'd2 : 32'd1);
            chk("rsp_result", 32'(rsp_result), 32'(e.q));
            chk("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
            chk("rsp_dz", 32'(rsp_dz), 32'(e.dz));
            if (rsp_ready[e.owner]) void'(exp_q.pop_front());
         end
      end
   end

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_dividend[i*W +: W] = a;
      req_divisor[i*W +: W]  = b;
   endtask

   task automatic wait_accept(input string nm, output int idx);
      idx = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if ((req_valid & req_ready) != 2'b00) begin
            idx = req_ready[1] ? 1 : 0;
            acc_cyc = cyc;
            break;
         end
      end
      if (idx < 0) chk({nm, "_accept_timeout"}, 32'(0), 32'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input string nm, input logic [1:0] ev, input logic [W-1:0] q,
                           input logic [W-1:0] r, input logic dz, input int lat);
      bit found = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) begin
            found = 1;
            break;
         end
      end
      if (!found) begin
         chk({nm, "_rsp_timeout"}, 32'(0), 32'(1));
      end else begin
         rsp_cyc = cyc;
         chk({nm, "_valid"}, 32'(rsp_valid), 32'(ev));
         chk({nm, "_q"}, 32'(rsp_result), 32'(q));
         chk({nm, "_r"}, 32'(rsp_remainder), 32'(r));
         chk({nm, "_dz"}, 32'(rsp_dz), 32'(dz));
         chk({nm, "_latency"}, 32'(cyc - acc_cyc), 32'(lat));
      end
   endtask

   task automatic get_rsp(input string nm, input logic [1:0] ev, input logic [W-1:0] q,
                          input logic [W-1:0] r, input logic dz, input int lat, input int hold);
      wait_rsp(nm, ev, q, r, dz, lat);
      @(posedge clk);
      repeat (hold) @(posedge clk);
      #1;
      rsp_ready = ev;
      @(posedge clk);
      #1;
      rsp_ready = 2'b00;
   endtask

   task automatic single(input string nm, input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz, input int lat);
      int idx;
      set_op(i, a, b);
      req_valid = (i == 1) ? 2'b10 : 2'b01;
      wait_accept(nm, idx);
      req_valid = 2'b00;
      get_rsp(nm, (i == 1) ? 2'b10 : 2'b01, q, r, dz, lat, 2);
   endtask

   initial begin
      int idx;
      int a1;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("reset_result", 32'(rsp_result), 32'(0));
      chk("reset_remainder", 32'(rsp_remainder), 32'(0));
      chk("reset_dz", 32'(rsp_dz), 32'(0));
      chk("reset_req_ready", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;

      // Contention: 0 wins first, then 1 wins while 0 re-requests.
      rsp_ready = 2'b11;
      set_op(0, 100, 7);
      set_op(1, 50, 5);
      req_valid = 2'b11;
      wait_accept("cont1", idx);
      chk("cont1_winner", 32'(idx), 32'(0));
      wait_rsp("cont1", 2'b01, 14, 2, 0, W + 1);
      wait_accept("cont2", idx);
      chk("cont2_winner", 32'(idx), 32'(1));
      req_valid = 2'b01;
      wait_rsp("cont2", 2'b10, 10, 0, 0, W + 1);
      wait_accept("cont3", idx);
      chk("cont3_winner", 32'(idx), 32'(0));
      req_valid = 2'b00;
      wait_rsp("cont3", 2'b01, 14, 2, 0, W + 1);
      @(posedge clk);
      #1;
      rsp_ready = 2'b00;

      single("u28_11", 0, 28, 11, 2, 6, 0, W + 1);

      // Back-to-back with rsp_ready held high.
      rsp_ready = 2'b11;
      set_op(0, 36, 6);
      req_valid = 2'b01;
      wait_accept("b2b1", idx);
      a1 = acc_cyc;
      set_op(0, 37, 6);
      wait_rsp("b2b1", 2'b01, 6, 0, 0, W + 1);
      wait_accept("b2b2", idx);
      chk("b2b_next_accept", 32'(acc_cyc), 32'(rsp_cyc + 1));
      chk("b2b_period", 32'(acc_cyc - a1), 32'(W + 2));
      req_valid = 2'b00;
      wait_rsp("b2b2", 2'b01, 6, 1, 0, W + 1);
      @(posedge clk);
      #1;
      rsp_ready = 2'b00;

      single("dz0", 0, 1234, 0, 16'hFFFF, 1234, 1, 1);
      single("dz1", 1, 7, 0, 16'hFFFF, 7, 1, 1);

`ifdef DIV_CTRL_SIGNED_EN
      single("s_m7_2", 0, 16'hFFF9, 2, 16'hFFFD, 16'hFFFF, 0, W + 1);
      single("s_min_m1", 0, 16'h8000, 16'hFFFF, 16'h8000, 0, 0, 1);
      single("s_7_m2", 1, 7, 16'hFFFE, 16'hFFFD, 1, 0, W + 1);
`else
      single("u_ffff_ffff", 1, 16'hFFFF, 16'hFFFF, 1, 0, 0, W + 1);
      single("u_5_9", 0, 5, 9, 0, 5, 0, W + 1);
      single("u_fff9_2", 0, 16'hFFF9, 2, 16'h7FFC, 1, 0, W + 1);
`endif

      // Reset in the middle of a divide discards it.
      set_op(0, 28, 11);
      req_valid = 2'b01;
      wait_accept("rst_mid", idx);
      req_valid = 2'b00;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_op(0, 37, 6);
      req_valid = 2'b01;
      @(negedge clk);
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_mid_result", 32'(rsp_result), 32'(0));
      chk("rst_mid_remainder", 32'(rsp_remainder), 32'(0));
      chk("rst_mid_req_ready", 32'(req_ready), 32'(1));
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      get_rsp("after_rst", 2'b01, 6, 1, 0, W + 1, 1);

      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
